node_receiver: RTL and testbench

//  Node-side endpoint for the network->node direction of the 2D mesh network.

---
 rtl/node_receiver.sv | 121 ++++++++++++
 tb/tb_node_receiver.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/node_receiver.sv
// Network->node receive endpoint: buffers router words in a small FIFO, throttles the router with a registered hold, counts words.
// Optional macro NODE_RX_DEST_CHECK_EN enables the destination compare that drives misrouteCount.
module node_receiver #(
    parameter int unsigned X_NODES    = 3,
    parameter int unsigned Y_NODES    = 3,
    parameter int unsigned FIFO_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned NODE_ID    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [FIFO_WIDTH-1:0] networkToNodeData,
    input  logic                  networkToNodeWriteRequest,
    output logic                  nodeToNetworkHoldRequest,
    output logic [FIFO_WIDTH-1:0] rxData,
    output logic                  rxValid,
    input  logic                  rxReady,
    output logic [15:0]           rxCount,
    output logic [7:0]            misrouteCount,
    output logic                  overflowError
);
    localparam int unsigned PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_BITS = PTR_BITS + 1;

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] FULL = 1'b1;

    // Elaboration-time sanity checks on the configuration
    if (NODE_ID >= X_NODES * Y_NODES) begin : gNodeIdCheck
        $error("node_receiver: NODE_ID out of mesh range");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gDepthCheck
        $error("node_receiver: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0]   wrPtr;
    logic [PTR_BITS-1:0]   rdPtr;
    logic [CNT_BITS-1:0]   occupancy;
    logic [CNT_BITS-1:0]   occupancyNext;
    logic [0:0]            state;
    logic [0:0]            stateNext;
    logic                  push;
    logic                  pop;
    logic                  overflowHit;

    assign rxValid                  = (occupancy != '0);
    assign rxData                   = rxValid ? mem[rdPtr] : '0;
    assign pop                      = rxValid & rxReady;
    assign nodeToNetworkHoldRequest = (state == FULL);
    // A concurrent pop frees a slot, so a write landing on a full buffer is still taken
    assign push        = networkToNodeWriteRequest & (~nodeToNetworkHoldRequest | pop);
    assign overflowHit = networkToNodeWriteRequest & nodeToNetworkHoldRequest & ~pop;

    always_comb begin
        occupancyNext = occupancy;
        case ({push, pop})
            2'b10:   occupancyNext = occupancy + CNT_BITS'(1);
            2'b01:   occupancyNext = occupancy - CNT_BITS'(1);
            default: occupancyNext = occupancy;
        endcase
    end

    // Hold FSM: state register drives the router hold directly
    always_comb begin
        stateNext = state;
        case (state)
            RUN:     if (occupancyNext == CNT_BITS'(FIFO_DEPTH)) stateNext = FULL;
            FULL:    if (pop && occupancyNext != CNT_BITS'(FIFO_DEPTH)) stateNext = RUN;
            default: stateNext = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            occupancy <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
        end else begin
            state     <= stateNext;
            occupancy <= occupancyNext;
            if (push) wrPtr <= wrPtr + PTR_BITS'(1);
            if (pop)  rdPtr <= rdPtr + PTR_BITS'(1);
        end
    end

    // Storage needs no reset: rxData is masked to zero while empty
    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= networkToNodeData;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rxCount       <= '0;
            overflowError <= 1'b0;
        end else begin
            if (push && rxCount != 16'hFFFF) rxCount <= rxCount + 16'd1;
            if (overflowHit) overflowError <= 1'b1;
        end
    end

`ifdef NODE_RX_DEST_CHECK_EN
    localparam int unsigned ADDR_BITS = $clog2(X_NODES * Y_NODES);

    logic misrouted;
    assign misrouted = push &&
        (networkToNodeData[FIFO_WIDTH-1 -: ADDR_BITS] != ADDR_BITS'(NODE_ID));

    always_ff @(posedge clk) begin
        if (reset) begin
            misrouteCount <= '0;
        end else if (misrouted && misrouteCount != 8'hFF) begin
            misrouteCount <= misrouteCount + 8'd1;
        end
    end
`else
    assign misrouteCount = 8'h00;
`endif

endmodule

// File: tb/tb_node_receiver.sv
// Bench for node_receiver: directed vector table, reset scenarios, and random traffic against a queue-based model.
module tb_node_receiver;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned NID   = 8;
`ifdef NODE_RX_DEST_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam logic [7:0] MIS1 = CHK ? 8'd1 : 8'd0;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] din;
    logic        wr;
    logic        hold;
    logic [31:0] rxData;
    logic        rxValid;
    logic        rdy;
    logic [15:0] rxCount;
    logic [7:0]  misrouteCount;
    logic        overflowError;

    node_receiver #(
        .X_NODES(3), .Y_NODES(3), .FIFO_WIDTH(32), .FIFO_DEPTH(DEPTH), .NODE_ID(NID)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .networkToNodeData        (din),
        .networkToNodeWriteRequest(wr),
        .nodeToNetworkHoldRequest (hold),
        .rxData                   (rxData),
        .rxValid                  (rxValid),
        .rxReady                  (rdy),
        .rxCount                  (rxCount),
        .misrouteCount            (misrouteCount),
        .overflowError            (overflowError)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: word queue plus counters
    logic [31:0] q[$];
    int unsigned mRx;
    int unsigned mMis;
    bit          mOvf;

    typedef struct {
        bit          w;
        logic [31:0] d;
        bit          r;
        bit          v;
        logic [31:0] ed;
        bit          h;
        logic [15:0] cnt;
        logic [7:0]  mis;
        bit          ovf;
    } vec_t;

    vec_t tv[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic modelClear();
        q.delete();
        mRx  = 0;
        mMis = 0;
        mOvf = 1'b0;
    endtask

    // Applies one clock edge's worth of the receive rules to the model
    task automatic modelEdge(input bit w, input logic [31:0] d, input bit r);
        bit full;
        bit p;
        full = (q.size() == DEPTH);
        p    = r && (q.size() > 0);
        if (w && full && !p) mOvf = 1'b1;
        if (p) void'(q.pop_front());
        if (w && (!full || p)) begin
            q.push_back(d);
            if (mRx < 65535) mRx++;
            if (CHK && d[31:28] != 4'(NID) && mMis < 255) mMis++;
        end
    endtask

    task automatic cycle(input bit w, input logic [31:0] d, input bit r);
        wr  = w;
        din = d;
        rdy = r;
        modelEdge(w, d, r);
        @(posedge clk);
        @(negedge clk);
        wr  = 1'b0;
        rdy = 1'b0;
    endtask

    task automatic checkModel(input string tag);
        logic [31:0] expData;
        expData = (q.size() != 0) ? q[0] : 32'h0;
        chk({tag, "_valid"}, 32'(rxValid), 32'(q.size() != 0));
        chk({tag, "_data"}, rxData, expData);
        chk({tag, "_hold"}, 32'(hold), 32'(q.size() == DEPTH));
        chk({tag, "_rxCount"}, 32'(rxCount), mRx);
        chk({tag, "_misroute"}, 32'(misrouteCount), mMis);
        chk({tag, "_overflow"}, 32'(overflowError), 32'(mOvf));
    endtask

    task automatic checkZero(input string tag);
        chk({tag, "_valid"}, 32'(rxValid), 32'h0);
        chk({tag, "_data"}, rxData, 32'h0);
        chk({tag, "_hold"}, 32'(hold), 32'h0);
        chk({tag, "_rxCount"}, 32'(rxCount), 32'h0);
        chk({tag, "_misroute"}, 32'(misrouteCount), 32'h0);
        chk({tag, "_overflow"}, 32'(overflowError), 32'h0);
    endtask

    task automatic doReset(input int n);
        reset = 1'b1;
        wr    = 1'b1;
        din   = 32'h8123_4567;
        rdy   = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        wr    = 1'b0;
        rdy   = 1'b0;
        modelClear();
    endtask

    initial begin
        bit          w;
        logic [31:0] d;

        tv[0]  = '{1'b1, 32'h81FF_FFFF, 1'b1, 1'b1, 32'h81FF_FFFF, 1'b0, 16'd1, 8'd0, 1'b0};
        tv[1]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 16'd1, 8'd0, 1'b0};
        tv[2]  = '{1'b1, 32'h8000_00A1, 1'b0, 1'b1, 32'h8000_00A1, 1'b0, 16'd2, 8'd0, 1'b0};
        tv[3]  = '{1'b1, 32'h8000_00B2, 1'b0, 1'b1, 32'h8000_00A1, 1'b0, 16'd3, 8'd0, 1'b0};
        tv[4]  = '{1'b1, 32'h8000_00C3, 1'b0, 1'b1, 32'h8000_00A1, 1'b0, 16'd4, 8'd0, 1'b0};
        tv[5]  = '{1'b1, 32'h8000_00D4, 1'b0, 1'b1, 32'h8000_00A1, 1'b1, 16'd5, 8'd0, 1'b0};
        tv[6]  = '{1'b1, 32'h8000_00E5, 1'b1, 1'b1, 32'h8000_00B2, 1'b1, 16'd6, 8'd0, 1'b0};
        tv[7]  = '{1'b1, 32'h8000_00F6, 1'b0, 1'b1, 32'h8000_00B2, 1'b1, 16'd6, 8'd0, 1'b1};
        tv[8]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_00C3, 1'b0, 16'd6, 8'd0, 1'b1};
        tv[9]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_00D4, 1'b0, 16'd6, 8'd0, 1'b1};
        tv[10] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_00E5, 1'b0, 16'd6, 8'd0, 1'b1};
        tv[11] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 16'd6, 8'd0, 1'b1};
        tv[12] = '{1'b1, 32'h3000_00AA, 1'b0, 1'b1, 32'h3000_00AA, 1'b0, 16'd7, MIS1, 1'b1};
        tv[13] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 16'd7, MIS1, 1'b1};

        reset = 1'b1;
        wr    = 1'b0;
        rdy   = 1'b0;
        din   = 32'h0;
        modelClear();

        // Reset held 3 cycles with writes requested: nothing may be stored
        doReset(3);
        checkZero("reset");
        cycle(1'b0, 32'h0, 1'b0);
        checkZero("post_reset_idle");

        // Directed vectors: single word, fill, full+concurrent, overflow, drain, misroute
        for (int i = 0; i < 14; i++) begin
            cycle(tv[i].w, tv[i].d, tv[i].r);
            chk($sformatf("vec%0d_valid", i), 32'(rxValid), 32'(tv[i].v));
            chk($sformatf("vec%0d_data", i), rxData, tv[i].ed);
            chk($sformatf("vec%0d_hold", i), 32'(hold), 32'(tv[i].h));
            chk($sformatf("vec%0d_rxCount", i), 32'(rxCount), 32'(tv[i].cnt));
            chk($sformatf("vec%0d_misroute", i), 32'(misrouteCount), 32'(tv[i].mis));
            chk($sformatf("vec%0d_overflow", i), 32'(overflowError), 32'(tv[i].ovf));
        end

        // Mid-burst reset with two words buffered
        cycle(1'b1, 32'h8000_0011, 1'b0);
        cycle(1'b1, 32'h8000_0022, 1'b0);
        checkModel("burst_pre");
        doReset(1);
        checkZero("midburst_reset");

        // Misroute saturation: a long stream of dest=0 words with the consumer always ready
        for (int i = 0; i < 270; i++) begin
            cycle(1'b1, {4'h0, 28'($urandom)}, 1'b1);
            checkModel("misroute_run");
        end
        chk("misroute_saturated", 32'(misrouteCount), CHK ? 32'd255 : 32'd0);

        // Random traffic, mostly honouring hold with occasional violations
        doReset(1);
        for (int i = 0; i < 3000; i++) begin
            w = ($urandom_range(0, 3) != 0);
            if (hold && $urandom_range(0, 15) != 0) w = 1'b0;
            d = $urandom;
            if ($urandom_range(0, 1) == 0) d[31:28] = 4'(NID);
            cycle(w, d, $urandom_range(0, 2) != 0);
            checkModel("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
